riscv_ahb3_mem_responder: RTL and testbench

- Parametrised multi-port AHB3 slave memory model; the synthesizable responder behind the core's instruction and data AHB3 buses in the PU-DV bench.
- Drives HRDATA/HREADY/HRESP per port from one shared word-addressed memory, with per-port runtime wait states and error injection.
- Generalises the fixed two-bus (ins/dat) pairing to NUM_PORTS independent AHB3 slave ports.

---
 rtl/riscv_ahb3_pkg.sv | 42 ++++
 rtl/riscv_ahb3_port_fsm.sv | 118 +++++++++++
 rtl/riscv_ahb3_mem_responder.sv | 113 +++++++++++
 tb/tb_riscv_ahb3_mem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ahb3_pkg.sv
// Shared AHB3 encodings, port FSM state type and lane-enable helper for the
// multi-port AHB3 memory responder.
package riscv_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        PortIdle,
        PortWait,
        PortData,
        PortErr1,
        PortErr2
    } port_state_e;

    // Byte lanes touched by a transfer; lanes above xlen/8 are always cleared.
    function automatic logic [7:0] bytes_en(input logic [2:0] hsize, input logic [2:0] addr_lsb,
                                            input int unsigned xlen);
        logic [7:0] mask;
        logic [2:0] lsb;
        lsb = (xlen == 32) ? {1'b0, addr_lsb[1:0]} : addr_lsb;
        case (hsize)
            HSIZE_BYTE:  mask = 8'h01;
            HSIZE_HWORD: mask = 8'h03;
            HSIZE_WORD:  mask = 8'h0f;
            default:     mask = 8'hff;
        endcase
        mask = mask << lsb;
        return (xlen == 32) ? (mask & 8'h0f) : mask;
    endfunction

endpackage

// File: rtl/riscv_ahb3_port_fsm.sv
// One AHB3 slave port: accepts transfers, counts wait states, produces the
// response and the write/read strobes consumed by the shared memory.
module riscv_ahb3_port_fsm
    import riscv_ahb3_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned PLEN   = 64,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned WAIT_W = 4,
    localparam int unsigned NB    = XLEN / 8,
    localparam int unsigned OFFW  = $clog2(XLEN / 8),
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [PLEN-1:0]   haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [1:0]        htrans,
    input  logic [WAIT_W-1:0] wait_cfg,
    input  logic              err_inject,
    output logic              hready,
    output logic              hresp,
    output logic              wr_en,
    output logic [AW-1:0]     wr_idx,
    output logic [NB-1:0]     wr_be,
    output logic              rd_load,
    output logic              rd_clr,
    output logic [AW-1:0]     rd_idx
);

    port_state_e         state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [OFFW+AW-1:0]  addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic                write_q, write_d;
    logic                accept, bad_req, misalign;
    logic [7:0]          be_full;

    always_comb begin
        case (hsize)
            HSIZE_BYTE:  misalign = 1'b0;
            HSIZE_HWORD: misalign = haddr[0];
            HSIZE_WORD:  misalign = |haddr[1:0];
            default:     misalign = |haddr[2:0];
        endcase
    end

    assign bad_req = err_inject | ((haddr >> OFFW) >= PLEN'(DEPTH)) | (hsize > 3'(OFFW)) | misalign;
    assign hready  = !(state_q inside {PortWait, PortErr1});
    assign hresp   = (state_q inside {PortErr1, PortErr2}) ? HRESP_ERROR : HRESP_OKAY;
    assign accept  = hsel & (htrans inside {HTRANS_NONSEQ, HTRANS_SEQ}) & hready;

    assign wr_en   = (state_q == PortData) & write_q;
    assign wr_idx  = addr_q[OFFW +: AW];
    assign be_full = bytes_en(size_q, addr_q[2:0], XLEN);
    assign wr_be   = be_full[NB-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        rd_load = 1'b0;
        rd_clr  = 1'b0;
        rd_idx  = addr_q[OFFW +: AW];
        case (state_q)
            PortWait: begin
                if (cnt_q == '0) begin
                    state_d = PortData;
                    rd_load = !write_q;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            PortErr1: state_d = PortErr2;
            default: begin
                // Idle, Data and Err2 all present HREADY=1 and may accept.
                state_d = PortIdle;
                if (accept) begin
                    addr_d  = haddr[OFFW+AW-1:0];
                    size_d  = hsize;
                    write_d = hwrite;
                    if (bad_req) begin
                        state_d = PortErr1;
                        rd_clr  = 1'b1;
                    end else if (wait_cfg == '0) begin
                        state_d = PortData;
                        rd_load = !hwrite;
                        rd_idx  = haddr[OFFW +: AW];
                    end else begin
                        state_d = PortWait;
                        cnt_d   = wait_cfg - WAIT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PortIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

endmodule

// File: rtl/riscv_ahb3_mem_responder.sv
// Multi-port AHB3 slave memory model: one shared word-addressed array behind
// NUM_PORTS independent ports with runtime wait states and error injection.
module riscv_ahb3_mem_responder
    import riscv_ahb3_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned PLEN      = 64,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned WAIT_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        HSEL,
    input  logic [NUM_PORTS*PLEN-1:0]   HADDR,
    input  logic [NUM_PORTS*XLEN-1:0]   HWDATA,
    output logic [NUM_PORTS*XLEN-1:0]   HRDATA,
    input  logic [NUM_PORTS-1:0]        HWRITE,
    input  logic [NUM_PORTS*3-1:0]      HSIZE,
    input  logic [NUM_PORTS*3-1:0]      HBURST,
    input  logic [NUM_PORTS*4-1:0]      HPROT,
    input  logic [NUM_PORTS*2-1:0]      HTRANS,
    input  logic [NUM_PORTS-1:0]        HMASTLOCK,
    output logic [NUM_PORTS-1:0]        HREADY,
    output logic [NUM_PORTS-1:0]        HRESP,
    input  logic [NUM_PORTS*WAIT_W-1:0] wait_cfg,
    input  logic [NUM_PORTS-1:0]        err_inject
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned AW = $clog2(DEPTH);

    logic [XLEN-1:0]      mem [DEPTH];
    logic [XLEN-1:0]      hrdata_q [NUM_PORTS];
    logic [XLEN-1:0]      hrdata_d [NUM_PORTS];
    logic [XLEN-1:0]      wdata    [NUM_PORTS];
    logic [AW-1:0]        wr_idx   [NUM_PORTS];
    logic [AW-1:0]        rd_idx   [NUM_PORTS];
    logic [NB-1:0]        wr_be    [NUM_PORTS];
    logic [NUM_PORTS-1:0] wr_en, rd_load, rd_clr;
    logic                 unused_inputs;

    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign wdata[p] = HWDATA[p*XLEN +: XLEN];
        assign HRDATA[p*XLEN +: XLEN] = hrdata_q[p];

        riscv_ahb3_port_fsm #(
            .XLEN   (XLEN),
            .PLEN   (PLEN),
            .DEPTH  (DEPTH),
            .WAIT_W (WAIT_W)
        ) u_fsm (
            .clk        (clk),
            .rst        (rst),
            .hsel       (HSEL[p]),
            .haddr      (HADDR[p*PLEN +: PLEN]),
            .hwrite     (HWRITE[p]),
            .hsize      (HSIZE[p*3 +: 3]),
            .htrans     (HTRANS[p*2 +: 2]),
            .wait_cfg   (wait_cfg[p*WAIT_W +: WAIT_W]),
            .err_inject (err_inject[p]),
            .hready     (HREADY[p]),
            .hresp      (HRESP[p]),
            .wr_en      (wr_en[p]),
            .wr_idx     (wr_idx[p]),
            .wr_be      (wr_be[p]),
            .rd_load    (rd_load[p]),
            .rd_clr     (rd_clr[p]),
            .rd_idx     (rd_idx[p])
        );
    end

    // Ascending port order makes the higher index win each contested lane.
    always_ff @(posedge clk) begin
        for (int q = 0; q < NUM_PORTS; q++) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_en[q] && wr_be[q][b]) begin
                    mem[wr_idx[q]][b*8 +: 8] <= wdata[q][b*8 +: 8];
                end
            end
        end
    end

    // Write-first: merge lanes committing on the same edge the read is loaded.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            hrdata_d[p] = hrdata_q[p];
            if (rd_clr[p]) begin
                hrdata_d[p] = '0;
            end else if (rd_load[p]) begin
                hrdata_d[p] = mem[rd_idx[p]];
                for (int q = 0; q < NUM_PORTS; q++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wr_en[q] && wr_be[q][b] && (wr_idx[q] == rd_idx[p])) begin
                            hrdata_d[p][b*8 +: 8] = wdata[q][b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NUM_PORTS; p++) hrdata_q[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) hrdata_q[p] <= hrdata_d[p];
        end
    end

endmodule

// File: tb/tb_riscv_ahb3_mem_responder.sv
// Scoreboard bench for the two-port AHB3 memory responder (XLEN=64, DEPTH=1024).
module tb_riscv_ahb3_mem_responder;

    typedef struct {
        bit          wr;
        logic [63:0] data;
        bit          resp;
        int          lows;
        string       name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   hsel, hwrite, hmastlock, err_inject, HREADY, HRESP;
    logic [127:0] haddr, hwdata, HRDATA;
    logic [5:0]   hsize, hburst;
    logic [7:0]   hprot, wait_cfg;
    logic [3:0]   htrans;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    bit   pend [2];
    int   low_c [2];

    riscv_ahb3_mem_responder #(
        .XLEN      (64),
        .PLEN      (64),
        .NUM_PORTS (2),
        .DEPTH     (1024),
        .WAIT_W    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .HSEL       (hsel),
        .HADDR      (haddr),
        .HWDATA     (hwdata),
        .HRDATA     (HRDATA),
        .HWRITE     (hwrite),
        .HSIZE      (hsize),
        .HBURST     (hburst),
        .HPROT      (hprot),
        .HTRANS     (htrans),
        .HMASTLOCK  (hmastlock),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .wait_cfg   (wait_cfg),
        .err_inject (err_inject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int p, input bit wr, input logic [63:0] d, input bit r,
                        input int w, input string nm);
        exp_t e;
        e.wr = wr; e.data = d; e.resp = r; e.lows = w; e.name = nm;
        if (p == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic check_done(input int p);
        exp_t e;
        bit   have;
        have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: port %0d completed, expected none", p);
        end else begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            chk({e.name, "_hresp"}, 64'(HRESP[p]), 64'(e.resp));
            chk({e.name, "_wait_cycles"}, 64'(low_c[p]), 64'(e.lows));
            if (!e.wr || e.resp) chk({e.name, "_hrdata"}, HRDATA[64*p +: 64], e.data);
        end
    endtask

    // Monitor: sees acceptances and completions on the falling edge.
    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0;
        low_c[0] = 0; low_c[1] = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend[0] = 1'b0;
                pend[1] = 1'b0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (pend[p]) begin
                        if (HREADY[p]) begin
                            check_done(p);
                            pend[p] = 1'b0;
                        end else begin
                            low_c[p]++;
                        end
                    end
                    if (hsel[p] && htrans[2*p+1] && HREADY[p]) begin
                        pend[p]  = 1'b1;
                        low_c[p] = 0;
                    end
                end
            end
        end
    end

    task automatic wait_done(input int p);
        bit done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (HREADY[p]) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout port %0d: got HREADY low 20 cycles, expected completion", p);
        end
        @(posedge clk); #1;
    endtask

    task automatic xfer(input int p, input bit wr, input logic [63:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata, input int w, input bit ei,
                        input logic [63:0] exp_d, input bit exp_r, input int exp_w,
                        input string nm);
        push(p, wr, exp_d, exp_r, exp_w, nm);
        hsel[p]            = 1'b1;
        htrans[2*p +: 2]   = 2'b10;
        haddr[64*p +: 64]  = addr;
        hwrite[p]          = wr;
        hsize[3*p +: 3]    = size;
        wait_cfg[4*p +: 4] = 4'(w);
        err_inject[p]      = ei;
        @(posedge clk); #1;
        hsel[p]            = 1'b0;
        htrans[2*p +: 2]   = 2'b00;
        err_inject[p]      = 1'b0;
        hwdata[64*p +: 64] = wdata;
        wait_done(p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        hsel = '0; hwrite = '0; hmastlock = '0; err_inject = '0;
        haddr = '0; hwdata = '0; hsize = '0; hburst = '0; hprot = '0;
        wait_cfg = '0; htrans = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_hready", 64'(HREADY), 64'h3);
        chk("reset_hresp", 64'(HRESP), 64'h0);
        chk("reset_hrdata", HRDATA[63:0] | HRDATA[127:64], 64'h0);

        // BUSY with HSEL is a zero-wait OKAY, no transfer.
        hsel[0] = 1'b1; htrans[1:0] = 2'b01;
        @(posedge clk); #1;
        chk("busy_hready", 64'(HREADY[0]), 64'h1);
        chk("busy_hresp", 64'(HRESP[0]), 64'h0);
        hsel[0] = 1'b0; htrans[1:0] = 2'b00;

        xfer(1, 1, 64'h100, 3'd3, 64'hDEADBEEF_CAFEF00D, 0, 0, '0, 0, 0, "wr_dword");
        xfer(0, 0, 64'h100, 3'd3, '0, 0, 0, 64'hDEADBEEF_CAFEF00D, 0, 0, "rd_dword");
        xfer(1, 1, 64'h103, 3'd0, 64'h00000000_A5000000, 0, 0, '0, 0, 0, "wr_byte");
        xfer(0, 0, 64'h100, 3'd3, '0, 0, 0, 64'hDEADBEEF_A5FEF00D, 0, 0, "rd_after_byte");
        xfer(0, 0, 64'h100, 3'd3, '0, 3, 0, 64'hDEADBEEF_A5FEF00D, 0, 3, "rd_wait3");
        xfer(1, 1, 64'h108, 3'd3, 64'h01234567_89ABCDEF, 2, 0, '0, 0, 2, "wr_wait2");
        xfer(1, 1, 64'h10E, 3'd1, 64'hBEEF0000_00000000, 0, 0, '0, 0, 0, "wr_hword");
        xfer(0, 0, 64'h108, 3'd3, '0, 1, 0, 64'hBEEF4567_89ABCDEF, 0, 1, "rd_wait1");

        xfer(0, 0, 64'h2000, 3'd3, '0, 0, 0, 64'h0, 1, 1, "err_range");
        xfer(1, 1, 64'h100, 3'd3, 64'hFFFFFFFF_FFFFFFFF, 0, 1, 64'h0, 1, 1, "err_inject");
        xfer(1, 1, 64'h102, 3'd2, 64'hFFFFFFFF_FFFFFFFF, 0, 0, 64'h0, 1, 1, "err_align");
        xfer(0, 0, 64'h100, 3'd4, '0, 2, 0, 64'h0, 1, 1, "err_size");
        xfer(0, 0, 64'h100, 3'd3, '0, 0, 0, 64'hDEADBEEF_A5FEF00D, 0, 0, "rd_after_err");

        // Same-cycle writes from both ports plus a pipelined read on port 0.
        xfer(0, 1, 64'h40, 3'd3, 64'h55555555_55555555, 0, 0, '0, 0, 0, "init40");
        push(0, 1, '0, 0, 0, "dual_wr_p0");
        push(1, 1, '0, 0, 0, "dual_wr_p1");
        push(0, 0, 64'h55555555_BBAA2211, 0, 0, "dual_rd_p0");
        hsel = 2'b11; htrans = 4'b1010; haddr = {64'h42, 64'h40};
        hwrite = 2'b11; hsize = {3'd1, 3'd2}; wait_cfg = '0;
        @(posedge clk); #1;
        hsel = 2'b01; htrans = 4'b0010; haddr[63:0] = 64'h40; hwrite[0] = 1'b0; hsize[2:0] = 3'd3;
        hwdata = {64'h00000000_BBAA0000, 64'h00000000_44332211};
        @(posedge clk); #1;
        hsel = '0; htrans = '0;
        wait_done(0);
        xfer(1, 0, 64'h40, 3'd3, '0, 0, 0, 64'h55555555_BBAA2211, 0, 0, "rd40_p1");

        // Asynchronous reset in the middle of a wait-stated write.
        hsel[1] = 1'b1; htrans[3:2] = 2'b10; haddr[127:64] = 64'h100; hwrite[1] = 1'b1;
        hsize[5:3] = 3'd3; wait_cfg[7:4] = 4'd5;
        @(posedge clk); #1;
        hsel[1] = 1'b0; htrans[3:2] = 2'b00; hwdata[127:64] = 64'h0;
        @(posedge clk); #1;
        chk("wait_before_reset", 64'(HREADY[1]), 64'h0);
        rst = 1'b0;
        #1;
        chk("async_reset_hready", 64'(HREADY), 64'h3);
        chk("async_reset_hresp", 64'(HRESP), 64'h0);
        chk("async_reset_hrdata", HRDATA[63:0] | HRDATA[127:64], 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; wait_cfg = '0;
        @(posedge clk); #1;
        xfer(0, 0, 64'h100, 3'd3, '0, 0, 0, 64'hDEADBEEF_A5FEF00D, 0, 0, "rd_after_abort");

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(q0.size() + q1.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
